// File: rtl/usb_ep_pkg.sv
// Purpose: shared constants and FSM encoding for the USB endpoint RX drain engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_ep_pkg;

    localparam int BYTE_AW = 11;    // byte address width into the RX buffer
    localparam int WORD_AW = 10;    // 16-bit word address width
    localparam int MAX_LEN = 1024;  // largest byte count a command may carry

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/fifo_sync_shift.sv
// Purpose: small synchronous shift-register FIFO; head always sits in entry 0.
// Latency: a push is visible at pop_data on the next cycle.
// Backpressure: caller watches count; a push into a full FIFO without a pop is dropped.
//
// Ports: clk/rst (sync, active-high), push/push_data, pop, pop_data (head),
//        count (entries held).
module fifo_sync_shift #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic             do_pop;
    logic             do_push;
    logic [CW-1:0]    wr_idx;

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        // Slot after the shift caused by a simultaneous pop.
        wr_idx  = cnt_q - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (wr_idx == CW'(i))) begin
                    mem_q[i] <= push_data;
                end
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_data = mem_q[0];
    assign count    = cnt_q;

endmodule

// File: rtl/usb_ep_rx_reader.sv
// Purpose: drain a byte range of the USB RX endpoint buffer onto a byte valid/ready stream.
// Latency: command accept at T -> first read T+1, first out_valid T+3; done the cycle after the last byte.
// Backpressure: out_ready low stalls the unpacker; reads stop once 2 words are outstanding.
//
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_addr/cmd_len command;
//        ep_rx_addr_0/ep_rx_re_0/ep_rx_data_1 buffer read port (data 1 cycle after re);
//        out_data/out_valid/out_last/out_ready byte stream; busy, done status.
module usb_ep_rx_reader
    import usb_ep_pkg::*;
#(
    parameter int EPDW = 16,
    parameter int EPAW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [BYTE_AW-1:0] cmd_addr,
    input  logic [BYTE_AW-1:0] cmd_len,
    output logic [EPAW-1:0]    ep_rx_addr_0,
    output logic               ep_rx_re_0,
    input  logic [EPDW-1:0]    ep_rx_data_1,
    output logic [7:0]         out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    rx_state_e          state_q, state_d;
    logic [BYTE_AW-1:0] ptr_q;      // current byte address
    logic [BYTE_AW-1:0] left_q;     // bytes still to emit
    logic [BYTE_AW-1:0] wleft_q;    // words still to fetch
    logic [EPAW-1:0]    waddr_q;    // next word address to read
    logic [1:0]         credits_q;  // words issued and not yet popped
    logic               rd_pend_q;  // read data arrives this cycle

    logic               accept;
    logic               issue;
    logic               fire;
    logic               final_byte;
    logic               pop;
    logic [BYTE_AW-1:0] nw;
    logic [EPDW-1:0]    head;
    logic [1:0]         fifo_cnt;
    logic [7:0]         byte_sel;

    fifo_sync_shift #(
        .DEPTH (2),
        .WIDTH (EPDW)
    ) u_word_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .push_data (ep_rx_data_1),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_cnt)
    );

    always_comb begin
        state_d    = state_q;
        accept     = (state_q == ST_IDLE) && cmd_valid;
        issue      = (state_q == ST_RUN) && (wleft_q != '0) && (credits_q < 2'd2);
        final_byte = (left_q == BYTE_AW'(1));
        out_valid  = (state_q == ST_RUN) && (fifo_cnt != 2'd0);
        fire       = out_valid && out_ready;
        // A word leaves the FIFO once its high byte or the command's last byte is taken.
        pop        = fire && (ptr_q[0] || final_byte);
        nw         = (BYTE_AW'(cmd_addr[0]) + cmd_len + BYTE_AW'(1)) >> 1;
        byte_sel   = ptr_q[0] ? head[15:8] : head[7:0];

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire && final_byte) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            left_q    <= '0;
            wleft_q   <= '0;
            waddr_q   <= '0;
            credits_q <= '0;
            rd_pend_q <= 1'b0;  // drops any read that was in flight
        end else begin
            state_q   <= state_d;
            rd_pend_q <= issue;
            credits_q <= credits_q + 2'(issue) - 2'(pop);
            if (accept) begin
                ptr_q   <= cmd_addr;
                left_q  <= cmd_len;
                wleft_q <= nw;
                waddr_q <= cmd_addr[BYTE_AW-1:1];
            end else begin
                if (issue) begin
                    waddr_q <= waddr_q + EPAW'(1);  // wraps 1023 -> 0
                    wleft_q <= wleft_q - BYTE_AW'(1);
                end
                if (fire) begin
                    ptr_q  <= ptr_q + BYTE_AW'(1);
                    left_q <= left_q - BYTE_AW'(1);
                end
            end
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign ep_rx_re_0   = issue;
    assign ep_rx_addr_0 = waddr_q;
    assign out_data     = out_valid ? byte_sel : 8'h00;
    assign out_last     = out_valid && final_byte;

endmodule
